plcp_tx_sequencer: RTL

//   Sequences one 802.11b long-preamble PLCP frame into the 7-bit scrambler datapath, one bit at a time.

---
 rtl/plcp_tx_sequencer_if.sv | 10 +
 rtl/plcp_tx_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/plcp_tx_sequencer_if.sv
// PSDU byte stream between the MAC byte source (master) and the PLCP sequencer (slave).
// The slave's ready is derived from registered state only, so it has no path from valid.
interface plcp_tx_sequencer_if;
    logic [7:0] psdu_data;
    logic       psdu_valid;
    logic       psdu_ready;

    modport master (output psdu_data, output psdu_valid, input psdu_ready);
    modport slave  (input psdu_data, input psdu_valid, output psdu_ready);
endinterface

// File: rtl/plcp_tx_sequencer.sv
// 802.11b long-preamble PLCP transmit sequencer: serialises SYNC, SFD, header, header CRC
// and PSDU bytes, one bit per BIT_DIV-cycle slot, into the scrambler datapath.
module plcp_tx_sequencer #(
    parameter int unsigned SYNC_LEN = 128,
    parameter logic [15:0] SFD_WORD = 16'hF3A0,
    parameter int unsigned BIT_DIV  = 11,
    parameter int unsigned LEN_W    = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [7:0]             signal_in,
    input  logic [7:0]             service_in,
    input  logic [15:0]            length_in,
    input  logic [LEN_W-1:0]       psdu_len,
    plcp_tx_sequencer_if.slave     psdu,
    output logic                   scr_bit,
    output logic                   scr_en,
    output logic                   scr_init,
    output logic                   busy,
    output logic                   done,
    output logic                   underrun
);

    localparam int unsigned SLOT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int unsigned IDX_W  = ($clog2(SYNC_LEN) > 5) ? $clog2(SYNC_LEN) : 5;
    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(BIT_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_SYNC, S_SFD, S_HDR, S_CRC, S_PSDU, S_DONE
    } state_t;

    state_t             state_q;
    logic [SLOT_W-1:0]  slot_q;
    logic [IDX_W-1:0]   idx_q;
    logic [15:0]        crc_q;
    logic [31:0]        hdr_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   fetch_q;
    logic [LEN_W-1:0]   sent_q;
    logic [7:0]         buf_q;
    logic               bufv_q;
    logic [6:0]         sh_q;
    logic               scr_bit_q, scr_en_q, scr_init_q, busy_q, done_q, underrun_q;

    state_t             fld_state;
    logic [IDX_W-1:0]   fld_idx;
    logic               tx_bit;
    logic               fld_last;
    logic [15:0]        crc_d;
    logic               slot_wrap;
    logic               emit;
    logic               first_byte_bit;
    logic               hs;

    // INIT emits SYNC bit 0, so it is treated as the SYNC field at index 0.
    always_comb begin
        fld_state = (state_q == S_INIT) ? S_SYNC : state_q;
        fld_idx   = (state_q == S_INIT) ? '0 : idx_q;
        tx_bit    = 1'b0;
        fld_last  = 1'b0;
        case (fld_state)
            S_SYNC: begin
                tx_bit   = 1'b1;
                fld_last = (fld_idx == IDX_W'(SYNC_LEN - 1));
            end
            S_SFD: begin
                tx_bit   = SFD_WORD[fld_idx[3:0]];
                fld_last = (fld_idx == IDX_W'(15));
            end
            S_HDR: begin
                tx_bit   = hdr_q[fld_idx[4:0]];
                fld_last = (fld_idx == IDX_W'(31));
            end
            S_CRC: begin
                tx_bit   = ~crc_q[4'd15 - fld_idx[3:0]];
                fld_last = (fld_idx == IDX_W'(15));
            end
            S_PSDU: begin
                tx_bit   = (fld_idx == '0) ? buf_q[0] : sh_q[0];
                fld_last = (fld_idx == IDX_W'(7));
            end
            default: ;
        endcase
        crc_d          = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ tx_bit) ? 16'h1021 : 16'h0000);
        slot_wrap      = (slot_q == SLOT_MAX);
        emit           = (state_q == S_INIT) ||
                         ((state_q inside {S_SYNC, S_SFD, S_HDR, S_CRC, S_PSDU}) && slot_wrap);
        first_byte_bit = (fld_state == S_PSDU) && (fld_idx == '0);
        hs             = psdu.psdu_valid && psdu.psdu_ready;
    end

    assign psdu.psdu_ready = !bufv_q && (state_q inside {S_HDR, S_CRC, S_PSDU}) && (fetch_q < len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            idx_q      <= '0;
            crc_q      <= '1;
            hdr_q      <= '0;
            len_q      <= '0;
            fetch_q    <= '0;
            sent_q     <= '0;
            buf_q      <= '0;
            bufv_q     <= 1'b0;
            sh_q       <= '0;
            scr_bit_q  <= 1'b0;
            scr_en_q   <= 1'b0;
            scr_init_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            scr_en_q   <= 1'b0;
            scr_init_q <= 1'b0;
            underrun_q <= 1'b0;
            if (hs) begin
                buf_q   <= psdu.psdu_data;
                bufv_q  <= 1'b1;
                fetch_q <= fetch_q + 1'b1;
            end
            if (abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                bufv_q  <= 1'b0;
                crc_q   <= '1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        done_q <= 1'b0;
                        if (start) begin
                            hdr_q      <= {length_in, service_in, signal_in};
                            len_q      <= psdu_len;
                            fetch_q    <= '0;
                            sent_q     <= '0;
                            bufv_q     <= 1'b0;
                            idx_q      <= '0;
                            busy_q     <= 1'b1;
                            scr_init_q <= 1'b1;
                            state_q    <= S_INIT;
                        end
                    end
                    S_INIT, S_SYNC, S_SFD, S_HDR, S_CRC, S_PSDU: begin
                        slot_q <= ((state_q == S_INIT) || slot_wrap) ? '0 : slot_q + 1'b1;
                        if (state_q == S_INIT) crc_q <= '1;
                        if (emit) begin
                            if (first_byte_bit && !bufv_q) begin
                                underrun_q <= 1'b1;
                                busy_q     <= 1'b0;
                                state_q    <= S_IDLE;
                            end else begin
                                scr_en_q  <= 1'b1;
                                scr_bit_q <= tx_bit;
                                if (fld_state == S_HDR) crc_q <= crc_d;
                                if (first_byte_bit) begin
                                    sh_q   <= buf_q[7:1];
                                    bufv_q <= 1'b0;
                                end else if (fld_state == S_PSDU) begin
                                    sh_q <= {1'b0, sh_q[6:1]};
                                end
                                if (fld_last) begin
                                    idx_q <= '0;
                                    case (fld_state)
                                        S_SYNC:  state_q <= S_SFD;
                                        S_SFD:   state_q <= S_HDR;
                                        S_HDR:   state_q <= S_CRC;
                                        S_CRC:   state_q <= (len_q == '0) ? S_DONE : S_PSDU;
                                        S_PSDU: begin
                                            sent_q <= sent_q + 1'b1;
                                            if ((sent_q + 1'b1) == len_q) state_q <= S_DONE;
                                        end
                                        default: state_q <= S_IDLE;
                                    endcase
                                end else begin
                                    idx_q   <= fld_idx + 1'b1;
                                    state_q <= fld_state;
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        // First DONE cycle raises done; the second returns to IDLE.
                        if (!done_q) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            done_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign scr_bit  = scr_bit_q;
    assign scr_en   = scr_en_q;
    assign scr_init = scr_init_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign underrun = underrun_q;

endmodule
